// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer scheduler: display scan-out beats the clear engine,
// which beats the plotter writer. Also registers the fetched pixel into 3/3/2 RGB.
module vga_fb_arbiter #(
  parameter int         H_ACTIVE    = 640,
  parameter int         V_ACTIVE    = 480,
  parameter int         SCALE_SHIFT = 2,
  parameter int         FB_W        = 160,
  parameter int         FB_DEPTH    = 19200,
  parameter int         ADDR_W      = 15,
  parameter logic [7:0] CLEAR_COLOR = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix,
  input  logic [9:0]        hPix,
  input  logic [9:0]        vPix,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ack,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_we,
  output logic [7:0]        fb_wdata,
  input  logic [7:0]        fb_rdata,
  output logic [2:0]        red,
  output logic [2:0]        green,
  output logic [1:0]        blue
);
  localparam logic [9:0]        H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0]        V_ACT = 10'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(FB_DEPTH);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(FB_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, CLR_WAIT, CLR_RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] disp_addr;
  logic              active, disp_gnt, clr_gnt, wr_gnt;
  logic              disp_v, blank_v;

  assign active    = (hPix < H_ACT) && (vPix < V_ACT);
  assign disp_addr = ADDR_W'(32'(vPix >> SCALE_SHIFT) * FB_W + 32'(hPix >> SCALE_SHIFT));

  // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
  assign disp_gnt = rst_n & pix & active;
  assign clr_gnt  = rst_n & ~disp_gnt & (state == CLR_RUN);
  assign wr_gnt   = rst_n & ~disp_gnt & (state == IDLE) & wr_req;

  assign wr_ack   = wr_gnt;
  assign clr_busy = (state != IDLE);

  always_comb begin
    fb_addr  = '0;
    fb_we    = 1'b0;
    fb_wdata = '0;
    if (disp_gnt) begin
      fb_addr = disp_addr;
    end else if (clr_gnt) begin
      fb_addr  = clr_cnt;
      fb_we    = 1'b1;
      fb_wdata = CLEAR_COLOR;
    end else if (wr_gnt) begin
      fb_addr  = wr_addr;
      fb_we    = (wr_addr < DEPTH);
      fb_wdata = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      unique case (state)
        IDLE:     if (clr_req) state <= CLR_WAIT;
        CLR_WAIT: if (vPix >= V_ACT) begin
          state   <= CLR_RUN;
          clr_cnt <= '0;
        end
        CLR_RUN:  if (clr_gnt) begin
          if (clr_cnt == LAST) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            clr_done <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default:  state <= IDLE;
      endcase
    end
  end

  // RAM read data lands one cycle after the strobe; blank strobes force black.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_v  <= 1'b0;
      blank_v <= 1'b0;
      red     <= '0;
      green   <= '0;
      blue    <= '0;
    end else begin
      disp_v  <= pix & active;
      blank_v <= pix & ~active;
      if (disp_v) begin
        red   <= fb_rdata[7:5];
        green <= fb_rdata[4:2];
        blue  <= fb_rdata[1:0];
      end else if (blank_v) begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed + randomized bench for vga_fb_arbiter; expectations come from the
// arbitration rules applied to plain arithmetic on the driven inputs.
module tb_vga_fb_arbiter;
  localparam int FB_DEPTH = 19200;

  logic        clk = 1'b0, rst_n = 1'b0, pix = 1'b0;
  logic [9:0]  hPix = '0, vPix = '0;
  logic        wr_req = 1'b0, clr_req = 1'b0;
  logic [14:0] wr_addr = '0;
  logic [7:0]  wr_data = '0, fb_rdata = '0;
  logic        wr_ack, clr_busy, clr_done, fb_we;
  logic [14:0] fb_addr;
  logic [7:0]  fb_wdata;
  logic [2:0]  red, green;
  logic [1:0]  blue;

  int checks = 0, errors = 0;

  vga_fb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .pix(pix), .hPix(hPix), .vPix(vPix),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .fb_addr(fb_addr), .fb_we(fb_we), .fb_wdata(fb_wdata), .fb_rdata(fb_rdata),
    .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic int disp_addr_of(input int h, input int v);
    return (v / 4) * 160 + h / 4;
  endfunction

  initial begin
    logic       pd, pb, act, ack_last;
    logic [7:0] exp_rgb;
    int         bad, done_cnt;

    // Reset state before any clock edge.
    #2;
    chk("rst_rgb", {red, green, blue}, 0);
    chk("rst_busy", clr_busy, 0);
    chk("rst_done", clr_done, 0);
    chk("rst_we", fb_we, 0);
    chk("rst_ack", wr_ack, 0);
    step();
    rst_n = 1'b1;
    step();

    // Display fetch and blanking.
    pix = 1'b1; hPix = 10'd8; vPix = 10'd4; settle();
    chk("disp_addr", fb_addr, 162);
    chk("disp_we", fb_we, 0);
    step();
    pix = 1'b0; fb_rdata = 8'hE5; step();
    chk("disp_rgb", {red, green, blue}, 8'hE5);
    pix = 1'b1; hPix = 10'd640; step();
    pix = 1'b0; fb_rdata = 8'h77; step();
    chk("blank_rgb", {red, green, blue}, 0);

    // Contention: display strobe stalls the writer for one cycle.
    pix = 1'b1; hPix = 10'd0; vPix = 10'd0;
    wr_req = 1'b1; wr_addr = 15'd100; wr_data = 8'h3C; settle();
    chk("cont_ack0", wr_ack, 0);
    chk("cont_we0", fb_we, 0);
    step();
    pix = 1'b0; settle();
    chk("cont_ack1", wr_ack, 1);
    chk("cont_we1", fb_we, 1);
    chk("cont_addr", fb_addr, 100);
    chk("cont_data", fb_wdata, 8'h3C);
    step();

    // Out-of-range write: acked but dropped.
    wr_addr = 15'd19200; wr_data = 8'h5A; settle();
    chk("oor_ack", wr_ack, 1);
    chk("oor_we", fb_we, 0);
    step();
    wr_req = 1'b0;

    // Mid-frame asynchronous reset with RGB lit and a clear pending.
    pix = 1'b1; hPix = 10'd100; vPix = 10'd100; step();
    pix = 1'b0; fb_rdata = 8'hFF; step();
    chk("pre_rst_rgb", {red, green, blue}, 8'hFF);
    clr_req = 1'b1; step();
    clr_req = 1'b0; settle();
    chk("pre_rst_busy", clr_busy, 1);
    wr_req = 1'b1; wr_addr = 15'd9; pix = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_rgb", {red, green, blue}, 0);
    chk("mid_rst_busy", clr_busy, 0);
    chk("mid_rst_we", fb_we, 0);
    chk("mid_rst_ack", wr_ack, 0);
    step();
    rst_n = 1'b1; wr_req = 1'b0; pix = 1'b0; step();

    // Randomized traffic in IDLE against the arbitration rules.
    pd = 1'b0; pb = 1'b0; exp_rgb = 8'h00; ack_last = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!wr_req || ack_last) begin
        wr_req  = 1'($urandom_range(0, 1));
        wr_addr = 15'($urandom_range(0, 19300));
        wr_data = 8'($urandom);
      end
      pix = ($urandom_range(0, 3) == 0);
      hPix = 10'($urandom_range(0, 700));
      vPix = 10'($urandom_range(0, 520));
      fb_rdata = 8'($urandom);
      settle();
      act = (hPix < 640) && (vPix < 480);
      if (pix && act) begin
        chk("rnd_disp_addr", fb_addr, disp_addr_of(hPix, vPix));
        chk("rnd_disp_we", fb_we, 0);
        chk("rnd_disp_ack", wr_ack, 0);
      end else if (wr_req) begin
        chk("rnd_wr_ack", wr_ack, 1);
        chk("rnd_wr_addr", fb_addr, wr_addr);
        chk("rnd_wr_we", fb_we, wr_addr < 19200);
        if (wr_addr < 19200) chk("rnd_wr_data", fb_wdata, wr_data);
      end else begin
        chk("rnd_idle_we", fb_we, 0);
        chk("rnd_idle_ack", wr_ack, 0);
        chk("rnd_idle_addr", fb_addr, 0);
      end
      ack_last = !(pix && act) && wr_req;
      if (pd) exp_rgb = fb_rdata;
      else if (pb) exp_rgb = 8'h00;
      pd = pix && act;
      pb = pix && !act;
      step();
      chk("rnd_rgb", {red, green, blue}, exp_rgb);
    end
    wr_req = 1'b0; pix = 1'b0; step();

    // Full clear with a writer waiting throughout.
    vPix = 10'd10; hPix = 10'd0;
    clr_req = 1'b1; wr_req = 1'b1; wr_addr = 15'd7; wr_data = 8'h11; settle();
    chk("clr_same_ack", wr_ack, 1);
    chk("clr_same_we", fb_we, 1);
    step();
    clr_req = 1'b0; wr_addr = 15'd55; wr_data = 8'hAA; settle();
    chk("clr_busy", clr_busy, 1);
    bad = 0; done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      vPix = 10'(10 + i * 12); hPix = 10'(i * 16);
      pix = (i % 4 == 0); clr_req = (i == 20);
      settle();
      if (fb_we !== 1'b0 || wr_ack !== 1'b0 || clr_busy !== 1'b1) bad++;
      step();
    end
    chk("clr_wait", bad, 0);
    clr_req = 1'b0; pix = 1'b0; vPix = 10'd480; settle();
    chk("clr_enter_we", fb_we, 0);
    step();
    bad = 0;
    for (int i = 0; i < FB_DEPTH; i++) begin
      pix = (i % 4 == 0);
      hPix = 10'($urandom_range(0, 799));
      vPix = 10'(480 + i / 440);
      settle();
      if (fb_we !== 1'b1 || fb_addr !== 15'(i) || fb_wdata !== 8'h00 ||
          wr_ack !== 1'b0 || clr_busy !== 1'b1) bad++;
      if (clr_done === 1'b1) done_cnt++;
      step();
    end
    chk("clr_run", bad, 0);
    pix = 1'b0; settle();
    chk("clr_done", clr_done, 1);
    chk("clr_busy_fall", clr_busy, 0);
    chk("clr_wr_ack", wr_ack, 1);
    chk("clr_wr_addr", fb_addr, 55);
    chk("clr_wr_we", fb_we, 1);
    chk("clr_wr_data", fb_wdata, 8'hAA);
    if (clr_done === 1'b1) done_cnt++;
    step();
    wr_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      if (clr_done === 1'b1) done_cnt++;
      step();
    end
    chk("clr_done_once", done_cnt, 1);

    // Reset in the middle of a clear.
    vPix = 10'd490; clr_req = 1'b1; step();
    clr_req = 1'b0; step();
    settle();
    chk("rclr_first", fb_addr, 0);
    for (int i = 0; i < 5000; i++) step();
    settle();
    chk("rclr_cnt", fb_addr, 5000);
    rst_n = 1'b0; #1;
    chk("rclr_busy", clr_busy, 0);
    chk("rclr_we", fb_we, 0);
    step();
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      settle();
      if (clr_done === 1'b1 || clr_busy === 1'b1) done_cnt++;
      step();
    end
    chk("rclr_idle", done_cnt, 0);
    clr_req = 1'b1; step();
    clr_req = 1'b0; step();
    settle();
    chk("rclr_restart_addr", fb_addr, 0);
    chk("rclr_restart_we", fb_we, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
